alu_exec_unit: RTL and testbench

- Execute-stage ALU. Consumes the 5-bit ALU operation code from the ALU control decoder, plus two XLEN-bit operands, and produces a registered result and zero flag.
- Sits between operand fetch and writeback/branch logic.
- Add, sub, and, xor and lui-pass complete in one cycle.
- Shifts run on an iterative one-bit-per-cycle shifter, so the block carries valid/ready handshakes on input and output.

---
 rtl/alu_exec_unit.sv | 167 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle add/sub/and/xor/lui, iterative one-bit-per-cycle shifter,
// registered result with valid/ready handshakes on both sides.
module alu_exec_unit #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned SHW  = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      alu_control,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam logic [4:0] OpAdd = 5'b00000;
   localparam logic [4:0] OpSub = 5'b00010;
   localparam logic [4:0] OpAnd = 5'b11100;
   localparam logic [4:0] OpXor = 5'b10000;
   localparam logic [4:0] OpSll = 5'b00100;
   localparam logic [4:0] OpSrl = 5'b10100;
   localparam logic [4:0] OpSra = 5'b10110;
   localparam logic [4:0] OpLui = 5'b11111;

   localparam logic [SHW-1:0] CntOne = SHW'(1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
   typedef enum logic [1:0] {ShSll, ShSrl, ShSra} shift_e;

   state_e          r_state;
   state_e          w_state_nxt;
   shift_e          r_kind;
   shift_e          w_kind_nxt;
   logic [XLEN-1:0] r_work;
   logic [XLEN-1:0] w_work_nxt;
   logic [SHW-1:0]  r_cnt;
   logic [SHW-1:0]  w_cnt_nxt;
   logic [XLEN-1:0] r_result;
   logic [XLEN-1:0] w_result_nxt;
   logic            r_zero;
   logic            w_zero_nxt;
   logic            r_illegal;
   logic            w_illegal_nxt;

   logic [XLEN-1:0] w_op_res;
   logic            w_op_ill;
   logic            w_is_shift;
   shift_e          w_op_kind;
   logic [SHW-1:0]  w_shamt;
   logic [XLEN-1:0] w_work_step;
   logic            w_accept;

   assign w_shamt   = op_b[SHW-1:0];
   assign in_ready  = (r_state == StIdle) | ((r_state == StDone) & out_ready);
   assign w_accept  = in_valid & in_ready;
   assign out_valid = (r_state == StDone);
   assign result    = r_result;
   assign zero      = r_zero;
   assign illegal   = r_illegal;

   // Operation decode; for shifts the single-cycle result is op_a, which is what a
   // zero shift amount produces.
   always_comb begin
      w_op_res   = op_a + op_b;
      w_op_ill   = 1'b0;
      w_is_shift = 1'b0;
      w_op_kind  = ShSll;
      case (alu_control)
         OpAdd: w_op_res = op_a + op_b;
         OpSub: w_op_res = op_a - op_b;
         OpAnd: w_op_res = op_a & op_b;
         OpXor: w_op_res = op_a ^ op_b;
         OpLui: w_op_res = op_b;
         OpSll: begin
            w_is_shift = 1'b1;
            w_op_kind  = ShSll;
            w_op_res   = op_a;
         end
         OpSrl: begin
            w_is_shift = 1'b1;
            w_op_kind  = ShSrl;
            w_op_res   = op_a;
         end
         OpSra: begin
            w_is_shift = 1'b1;
            w_op_kind  = ShSra;
            w_op_res   = op_a;
         end
         default: w_op_ill = 1'b1;
      endcase
   end

   always_comb begin
      case (r_kind)
         ShSll:   w_work_step = {r_work[XLEN-2:0], 1'b0};
         ShSrl:   w_work_step = {1'b0, r_work[XLEN-1:1]};
         ShSra:   w_work_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
         default: w_work_step = r_work;
      endcase
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_kind_nxt    = r_kind;
      w_work_nxt    = r_work;
      w_cnt_nxt     = r_cnt;
      w_result_nxt  = r_result;
      w_zero_nxt    = r_zero;
      w_illegal_nxt = r_illegal;
      case (r_state)
         StIdle, StDone: begin
            if (w_accept) begin
               if (w_is_shift && (w_shamt != '0)) begin
                  w_state_nxt = StShift;
                  w_kind_nxt  = w_op_kind;
                  w_work_nxt  = op_a;
                  w_cnt_nxt   = w_shamt;
               end else begin
                  w_state_nxt   = StDone;
                  w_result_nxt  = w_op_res;
                  w_zero_nxt    = (w_op_res == '0);
                  w_illegal_nxt = w_op_ill;
               end
            end else if ((r_state == StDone) && out_ready) begin
               w_state_nxt = StIdle;
            end
         end
         StShift: begin
            w_work_nxt = w_work_step;
            w_cnt_nxt  = r_cnt - CntOne;
            if (r_cnt == CntOne) begin
               w_state_nxt   = StDone;
               w_result_nxt  = w_work_step;
               w_zero_nxt    = (w_work_step == '0);
               w_illegal_nxt = 1'b0;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_kind    <= ShSll;
         r_work    <= '0;
         r_cnt     <= '0;
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_kind    <= w_kind_nxt;
         r_work    <= w_work_nxt;
         r_cnt     <= w_cnt_nxt;
         r_result  <= w_result_nxt;
         r_zero    <= w_zero_nxt;
         r_illegal <= w_illegal_nxt;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: scoreboard queue filled at issue, drained when
// out_valid is seen; inputs driven and outputs sampled on the falling edge.
module tb_alu_exec_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  alu_control;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   localparam logic [4:0] CAdd = 5'b00000;
   localparam logic [4:0] CSub = 5'b00010;
   localparam logic [4:0] CAnd = 5'b11100;
   localparam logic [4:0] CXor = 5'b10000;
   localparam logic [4:0] CSll = 5'b00100;
   localparam logic [4:0] CSrl = 5'b10100;
   localparam logic [4:0] CSra = 5'b10110;
   localparam logic [4:0] CLui = 5'b11111;
   localparam logic [4:0] CBad = 5'b01010;

   alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_control(alu_control),
      .op_a       (op_a),
      .op_b       (op_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .zero       (zero),
      .illegal    (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a,
                                         input logic [31:0] b, output logic ill);
      ill = 1'b0;
      case (c)
         CAdd:    model = a + b;
         CSub:    model = a - b;
         CAnd:    model = a & b;
         CXor:    model = a ^ b;
         CLui:    model = b;
         CSll:    model = a << b[4:0];
         CSrl:    model = a >> b[4:0];
         CSra:    model = 32'($signed(a) >>> b[4:0]);
         default: begin
            model = a + b;
            ill   = 1'b1;
         end
      endcase
   endfunction

   task automatic send(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic ordy);
      logic [31:0] r;
      logic        ill;
      r = model(c, a, b, ill);
      exp_q.push_back('{r, (r == 32'd0), ill});
      in_valid    = 1'b1;
      alu_control = c;
      op_a        = a;
      op_b        = b;
      out_ready   = ordy;
   endtask

   // Empty queue yields X so the following comparison fails.
   task automatic pop_exp(output exp_t e);
      if (exp_q.size() == 0) e = 'x;
      else e = exp_q.pop_front();
   endtask

   // Counts falling edges from the issue edge until out_valid, bounded.
   task automatic issue_wait(output int lat, output int ready_hi);
      lat      = 0;
      ready_hi = 0;
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         if (in_ready !== 1'b0) ready_hi++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({out_valid, result, zero, illegal} !== {1'b0, 32'd0, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_outputs: got v=%b r=%h z=%b i=%b want 0/0/0/0",
                  out_valid, result, zero, illegal);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_overflow;
      int   lat, rh;
      exp_t e;
      send(CAdd, 32'hFFFF_FFFF, 32'd1, 1'b1);
      issue_wait(lat, rh);
      n_checks++;
      if (lat != 1 || out_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL overflow_latency: got %0d valid=%b want 1 valid=1", lat, out_valid);
      end
      pop_exp(e);
      n_checks++;
      if ({result, zero, illegal} !== {32'h0, 1'b1, 1'b0} || e !== {result, zero, illegal}) begin
         n_errors++;
         $display("FAIL overflow_result: got %h/%b/%b want %h/%b/%b",
                  result, zero, illegal, e.res, e.z, e.ill);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL overflow_to_idle: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      send(CSub, 32'd5, 32'd7, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (i == 0) send(CXor, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b1);
         else if (i == 1) send(CLui, 32'hDEAD_BEEF, 32'h1234_5000, 1'b1);
         else in_valid = 1'b0;
         pop_exp(e);
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b1 || {result, zero, illegal} !== e) begin
            n_errors++;
            $display("FAIL b2b_%0d: got v=%b rdy=%b %h/%b/%b want v=1 rdy=1 %h/%b/%b", i,
                     out_valid, in_ready, result, zero, illegal, e.res, e.z, e.ill);
         end
         @(negedge clk);
      end
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_idle: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_shifts;
      logic [4:0]  c   [4] = '{CSra, CSrl, CSll, CSrl};
      logic [31:0] a   [4] = '{32'h8000_0000, 32'h8000_0000, 32'd1, 32'hABCD_0000};
      logic [31:0] b   [4] = '{32'd4, 32'd4, 32'd31, 32'h20};
      logic [31:0] r   [4] = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'hABCD_0000};
      int          el  [4] = '{5, 5, 32, 1};
      int          lat, rh;
      exp_t        e;
      for (int i = 0; i < 4; i++) begin
         send(c[i], a[i], b[i], 1'b1);
         issue_wait(lat, rh);
         n_checks++;
         if (lat != el[i] || rh != 0) begin
            n_errors++;
            $display("FAIL shift_%0d_timing: got lat=%0d ready_hi=%0d want lat=%0d ready_hi=0",
                     i, lat, rh, el[i]);
         end
         pop_exp(e);
         n_checks++;
         if (out_valid !== 1'b1 || result !== r[i] || {result, zero, illegal} !== e) begin
            n_errors++;
            $display("FAIL shift_%0d_result: got v=%b %h/%b/%b want %h/%b/%b", i, out_valid,
                     result, zero, illegal, r[i], e.z, e.ill);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure;
      exp_t e;
      send(CAnd, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
      @(negedge clk);
      alu_control = CAdd;
      op_a        = 32'h1111_1111;
      pop_exp(e);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {result, zero, illegal} !== e ||
             result !== 32'h0F00_0F00) begin
            n_errors++;
            $display("FAIL bp_hold_%0d: got v=%b rdy=%b %h/%b/%b want v=1 rdy=0 %h/%b/%b", i,
                     out_valid, in_ready, result, zero, illegal, e.res, e.z, e.ill);
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_illegal;
      int   lat, rh;
      exp_t e;
      send(CBad, 32'd2, 32'd3, 1'b1);
      issue_wait(lat, rh);
      pop_exp(e);
      n_checks++;
      if (lat != 1 || {result, zero, illegal} !== {32'd5, 1'b0, 1'b1} ||
          {result, zero, illegal} !== e) begin
         n_errors++;
         $display("FAIL illegal: got lat=%0d %h/%b/%b want lat=1 00000005/0/1", lat,
                  result, zero, illegal);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_shift;
      int stale;
      in_valid    = 1'b1;
      alu_control = CSll;
      op_a        = 32'h0000_0003;
      op_b        = 32'd20;
      out_ready   = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_shift_busy: got v=%b rdy=%b want v=0 rdy=0", out_valid, in_ready);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || illegal !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_shift_reset: got v=%b r=%h z=%b i=%b want 0/0/0/0",
                  out_valid, result, zero, illegal);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_shift_ready: got %b want 1", in_ready);
      end
      stale = 0;
      repeat (30) begin
         if (out_valid !== 1'b0) stale++;
         @(negedge clk);
      end
      n_checks++;
      if (stale != 0) begin
         n_errors++;
         $display("FAIL mid_shift_stale: got %0d valid cycles want 0", stale);
      end
   endtask

   task automatic test_random;
      logic [4:0] codes [9] = '{CAdd, CSub, CAnd, CXor, CSll, CSrl, CSra, CLui, CBad};
      logic [4:0] c;
      logic [31:0] a, b;
      int   lat, rh, el;
      exp_t e;
      for (int i = 0; i < 24; i++) begin
         c = codes[$urandom_range(0, 8)];
         a = $urandom;
         b = $urandom;
         if (i % 3 == 0) a[31] = 1'b1;
         el = ((c == CSll || c == CSrl || c == CSra) && b[4:0] != 5'd0) ? int'(b[4:0]) + 1 : 1;
         send(c, a, b, 1'b1);
         issue_wait(lat, rh);
         pop_exp(e);
         n_checks++;
         if (lat != el || out_valid !== 1'b1 || {result, zero, illegal} !== e) begin
            n_errors++;
            $display("FAIL rand_%0d op=%b a=%h b=%h: got lat=%0d %h/%b/%b want lat=%0d %h/%b/%b",
                     i, c, a, b, lat, result, zero, illegal, el, e.res, e.z, e.ill);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      in_valid    = 1'b0;
      alu_control = 5'd0;
      op_a        = 32'd0;
      op_b        = 32'd0;
      out_ready   = 1'b0;
      rst_n       = 1'b0;
      test_reset();
      test_overflow();
      test_back_to_back();
      test_shifts();
      test_backpressure();
      test_illegal();
      test_reset_mid_shift();
      test_random();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
